// File: rtl/iopmp_chk_seq_pkg.sv
// Shared types and encodings for the sequential IOPMP access checker.
package iopmp_chk_seq_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned PMPADDR_W = 30;
  localparam int unsigned CFG_W     = 8;

  localparam int unsigned CFG_R    = 0;
  localparam int unsigned CFG_W_B  = 1;
  localparam int unsigned CFG_X    = 2;
  localparam int unsigned CFG_A_LO = 3;
  localparam int unsigned CFG_A_HI = 4;
  localparam int unsigned CFG_L    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_EXEC  = 2'b11
  } req_type_t;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } amode_t;

  // Field order mirrors the cfg byte: L[7] rsvd[6:5] A[4:3] X[2] W[1] R[0].
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    amode_t     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  // Permission bit chosen by access type; type 00 is never permitted on a hit.
  function automatic logic perm_sel(input pmpcfg_t c, input req_type_t t);
    case (t)
      REQ_READ:  return c.r;
      REQ_WRITE: return c.w;
      REQ_EXEC:  return c.x;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iopmp_entry_cmp.sv
// Single-entry address comparator: match for one entry plus addr >= base for the next TOR bottom.
module iopmp_entry_cmp
  import iopmp_chk_seq_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  input  logic [PMPADDR_W-1:0] pmpaddr,
  input  amode_t               mode,
  input  logic                 bottom_flag,
  output logic                 hit,
  output logic                 addr_ge
);

  logic                 borrow;
  logic [ADDR_W-1:0]    unused_diff;
  logic [PMPADDR_W-1:0] napot_mask;
  logic                 run;

  // 33-bit subtract; the borrow out is the unsigned less-than.
  assign {borrow, unused_diff} = {1'b0, addr} - {1'b0, pmpaddr, 2'b00};
  assign addr_ge = ~borrow;

  // Clear mask bits up to and including the first zero of pmpaddr (all ones clears everything).
  always_comb begin
    napot_mask = '1;
    run        = 1'b1;
    for (int unsigned i = 0; i < PMPADDR_W; i++) begin
      if (run) napot_mask[i] = 1'b0;
      run = run & pmpaddr[i];
    end
  end

  always_comb begin
    hit = 1'b0;
    case (mode)
      A_TOR:   hit = bottom_flag & borrow;
      A_NA4:   hit = (addr[ADDR_W-1:2] == pmpaddr);
      A_NAPOT: hit = (((addr[ADDR_W-1:2] ^ pmpaddr) & napot_mask) == '0);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/iopmp_chk_seq.sv
// Sequential IOPMP checker: scans one entry per cycle, first match wins, result held until consumed.
module iopmp_chk_seq
  import iopmp_chk_seq_pkg::*;
#(
  parameter  int unsigned NUM_ENTRY = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic              cpuclk,
  input  logic              cpurst_b,
  input  logic              cfg_wen,
  input  logic              cfg_sel,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_rdy,
  input  logic              req_vld,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_type,
  output logic              req_rdy,
  output logic              resp_vld,
  input  logic              resp_rdy,
  output logic              resp_allow,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  resp_idx,
  input  logic              dflt_allow
);

  state_t               state_q, state_d;
  pmpcfg_t              cfg_q     [NUM_ENTRY];
  logic [PMPADDR_W-1:0] pmpaddr_q [NUM_ENTRY];

  logic [ADDR_W-1:0]    addr_q;
  req_type_t            type_q;
  logic                 dflt_q;
  logic [IDX_W-1:0]     scan_idx_q;
  logic                 bottom_q;

  logic                 cmp_hit;
  logic                 cmp_ge;
  logic                 accept;
  logic                 last_entry;
  logic                 scan_end;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 tor_lock;
  logic                 cfg_wr_en;
  logic                 addr_wr_en;
  logic                 unused_bits;

  assign req_rdy    = (state_q == ST_IDLE);
  assign cfg_rdy    = cfg_wen && (state_q == ST_IDLE);
  assign accept     = req_vld && req_rdy;
  assign last_entry = (scan_idx_q == IDX_W'(NUM_ENTRY - 1));
  assign scan_end   = (state_q == ST_SCAN) && (cmp_hit || last_entry);

  iopmp_entry_cmp u_cmp (
    .addr        (addr_q),
    .pmpaddr     (pmpaddr_q[scan_idx_q]),
    .mode        (cfg_q[scan_idx_q].a),
    .bottom_flag (bottom_q),
    .hit         (cmp_hit),
    .addr_ge     (cmp_ge)
  );

  // Lock filtering: a locked entry, or a locked TOR entry above, protects pmpaddr.
  always_comb begin
    nxt_idx    = cfg_idx + IDX_W'(1);
    tor_lock   = (cfg_idx != IDX_W'(NUM_ENTRY - 1)) && cfg_q[nxt_idx].l &&
                 (cfg_q[nxt_idx].a == A_TOR);
    cfg_wr_en  = cfg_rdy && !cfg_sel && !cfg_q[cfg_idx].l;
    addr_wr_en = cfg_rdy && cfg_sel && !cfg_q[cfg_idx].l && !tor_lock;
  end

  always_comb begin
    unused_bits = ^cfg_wdata[31:30];
    for (int unsigned i = 0; i < NUM_ENTRY; i++) unused_bits = unused_bits ^ (^cfg_q[i].rsvd);
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_vld)                  state_d = ST_SCAN;
      ST_SCAN: if (cmp_hit || last_entry)    state_d = ST_RESP;
      ST_RESP: if (resp_rdy)                 state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        cfg_q[i]     <= '0;
        pmpaddr_q[i] <= '0;
      end
    end else begin
      if (cfg_wr_en)  cfg_q[cfg_idx]     <= pmpcfg_t'(cfg_wdata[CFG_W-1:0]);
      if (addr_wr_en) pmpaddr_q[cfg_idx] <= cfg_wdata[PMPADDR_W-1:0];
    end
  end

  // Request capture, scan progress and response latch.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      addr_q     <= '0;
      type_q     <= REQ_NONE;
      dflt_q     <= 1'b0;
      scan_idx_q <= '0;
      bottom_q   <= 1'b1;
      resp_vld   <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= '0;
      resp_allow <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        type_q     <= req_type_t'(req_type);
        dflt_q     <= dflt_allow;
        scan_idx_q <= '0;
        bottom_q   <= 1'b1;
      end else if (state_q == ST_SCAN) begin
        scan_idx_q <= scan_idx_q + IDX_W'(1);
        bottom_q   <= cmp_ge;
      end

      if (scan_end) begin
        resp_vld   <= 1'b1;
        resp_hit   <= cmp_hit;
        resp_idx   <= cmp_hit ? scan_idx_q : '0;
        resp_allow <= cmp_hit ? perm_sel(cfg_q[scan_idx_q], type_q) : dflt_q;
      end else if (resp_vld && resp_rdy) begin
        resp_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/iopmp_chk_seq.md
IOPMP_CHK_SEQ -- requirements
Module: iopmp_chk_seq

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 8, number of IOPMP entries scanned (power of two, 2..16).
REQ-002 SHALL have ports:
- cpuclk  in  1  sole clock, rising edge.
- cpurst_b  in  1  reset; asynchronous, active-low.
- cfg_wen  in  1  config write strobe.
- cfg_sel  in  1  0: write entry cfg byte, 1: write entry pmpaddr.
- cfg_idx  in  log2(NUM_ENTRY)  entry index.
- cfg_wdata  in  32  write data (cfg byte in [7:0]: R[0] W[1] X[2] A[4:3] L[7]).
- cfg_rdy  out  1  config write accepted this cycle.
- req_vld  in  1  access check request.
- req_addr  in  32  access byte address.
- req_type  in  2  01 read, 10 write, 11 execute.
- req_rdy  out  1  request accepted when req_vld&&req_rdy.
- resp_vld  out  1  result valid.
- resp_rdy  in  1  result consumed when resp_vld&&resp_rdy.
- resp_allow  out  1  access permitted.
- resp_hit  out  1  some entry matched.
- resp_idx  out  log2(NUM_ENTRY)  matching entry index (0 if no hit).
- dflt_allow  in  1  permission when no entry matches (sampled at request accept).

Function
REQ-003 SHALL implement FSM IDLE, SCAN, RESP; reset state IDLE.
REQ-004 req_rdy SHALL be 1 only in IDLE; cfg_rdy SHALL equal cfg_wen && state==IDLE.
REQ-005 On accept, SHALL register req_addr, req_type, dflt_allow, clear scan index to 0, set TOR-bottom flag to 1, enter SCAN next cycle.
REQ-006 In SCAN, SHALL evaluate exactly one entry per cycle (index k in k-th SCAN cycle) through one comparator instance.
REQ-007 Match rules, base B = {pmpaddr[29:0],2'b00}: A=00 OFF never matches; A=01 TOR matches if bottom_flag && addr<B (33-bit unsigned subtract, borrow bit = less-than); A=10 NA4 matches if addr[31:2]==pmpaddr[29:0]; A=11 NAPOT matches under mask from trailing ones of pmpaddr[29:0] (0 ones -> 8B ... 29 ones -> 4GB, all ones -> mask 0).
REQ-008 After each SCAN cycle the bottom flag SHALL become (addr >= B of entry k), regardless of entry k's mode.
REQ-009 First (lowest-index) matching entry SHALL win; on match at k, SHALL latch resp_hit=1, resp_idx=k, resp_allow = permission bit selected by req_type (R/W/X), enter RESP next cycle.
REQ-010 If entry NUM_ENTRY-1 evaluated without match, SHALL latch resp_hit=0, resp_idx=0, resp_allow=registered dflt_allow, enter RESP.
REQ-011 Latency: match at entry k -> resp_vld asserted k+2 cycles after accept cycle; miss -> NUM_ENTRY+1 cycles.
REQ-012 req_type 00 SHALL be treated as a miss-free deny: resp_allow=0 on hit, dflt_allow on miss unchanged.
REQ-013 In RESP, resp_vld=1 and all resp_* stable until resp_rdy; on handshake return to IDLE; no new request accepted in the same cycle.
REQ-014 Config write to entry with L=1 SHALL be dropped (cfg_rdy still pulses); L clears only by reset. pmpaddr write of entry i SHALL also be dropped if entry i+1 has L=1 and A=01.
REQ-015 Config writes outside IDLE SHALL be stalled (cfg_rdy=0); config SHALL never change during a scan.

Reset
REQ-016 On cpurst_b low, asynchronously: state IDLE, all cfg bytes 0, all pmpaddr 0, resp_vld 0, resp_allow 0, resp_hit 0, resp_idx 0, req_rdy reflects IDLE (1 after release).
REQ-017 Reset mid-SCAN or mid-RESP SHALL abort the transaction with no response produced.

Structure
REQ-018 Shared package SHALL hold: state encoding, req_type codes, cfg bit positions (R,W,X,A,L), A-mode codes OFF/TOR/NA4/NAPOT.
REQ-019 One sub-module iopmp_entry_cmp (combinational: addr, pmpaddr, mode, bottom_flag -> hit, addr_ge); NAPOT mask via priority trailing-ones decode inside it.

Verification
REQ-020 Entry0 NA4 pmpaddr=0x0400_0000 cfg R=1; read 0x1000_0000 -> resp_hit=1, idx=0, allow=1, resp_vld 2 cycles after accept.
REQ-021 Entry2 TOR pmpaddr=0x0000_4000 (top 0x1_0000), entry1 pmpaddr=0x0000_2000 OFF, entry2 W=0; write 0x0000_8000 -> hit idx=2, allow=0, latency 4.
REQ-022 All entries OFF, dflt_allow=1, exec 0xFFFF_FFFC -> hit=0, allow=1, latency NUM_ENTRY+1.
REQ-023 Entry3 NAPOT pmpaddr=0x0000_03FF (8KB at 0), X=1 and entry5 NA4 same address: exec 0x0000_1FFC -> idx=3 wins; 0x0000_2000 -> not entry3.
REQ-024 Lock entry1 (L=1), rewrite cfg -> unchanged readback via behaviour; cfg_wen during SCAN -> cfg_rdy=0 until RESP handshake completes; resp_rdy held low 5 cycles -> outputs stable.
REQ-025 Assert cpurst_b low in SCAN cycle 3 -> resp_vld 0, state IDLE, config cleared, next request checks against reset config.
